// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle RV32I control unit
package mc_pkg;

  // FSM states of the multicycle sequencer
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_UIMM,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRLINK,
    S_TRAP
  } state_e;

  // Operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // RV32I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Writeback / PC result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // ALUControl encodings produced by aludec
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/flag inputs and datapath controls of the sequencer
// master: the control unit (drives controls, reads instruction fields, flags, mem_ready)
// slave : the datapath side (drives instruction fields, flags, mem_ready)
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             Zero;
  logic             Neg;
  logic             Carry;
  logic             Ovf;
  logic             mem_ready;
  logic             MemRead;
  logic             MemWrite;
  logic             AdrSrc;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic [2:0]       ImmSrc;
  logic [3:0]       ALUControl;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, funct3, funct7b5, Zero, Neg, Carry, Ovf, mem_ready,
    output MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
    output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, retired
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Neg, Carry, Ovf, mem_ready,
    input  MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
    input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, illegal, retired
  );
endinterface

// File: rtl/aludec.sv
// rtl/aludec.sv - ALU decoder: maps ALUOp and instruction fields to ALUControl
// op5 in (opcode bit 5, R-type vs I-type), funct3 in, funct7b5 in, ALUOp in, ALUControl out
module aludec
  import mc_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_e     ALUOp,
  output logic [3:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // bit 30 means SUB only for R-type; in addi it is immediate data
          3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_AND;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with memory handshake, trap and retire counter
// clk, reset (sync active-high); bus: master side of multicycle_ctrl_if
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter int MEM_HANDSHAKE   = 1,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  state_e           ill_next;
  aluop_e           alu_op;
  logic             rdy, taken, br_legal, retire;
  logic             mem_read, mem_write, ir_write, pc_write, reg_write, illegal;

  assign rdy      = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
  assign ill_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;

  // Branch condition from SUB flags; Carry is no-borrow, so unsigned a<b is !Carry
  always_comb begin
    taken    = 1'b0;
    br_legal = 1'b1;
    case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.Neg ^ bus.Ovf;
      3'b101:  taken = !(bus.Neg ^ bus.Ovf);
      3'b110:  taken = !bus.Carry;
      3'b111:  taken = bus.Carry;
      default: br_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RS2;
    bus.ResultSrc = RES_ALUOUT;
    bus.ImmSrc    = IMM_I;
    alu_op        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read      = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        ir_write      = rdy;
        pc_write      = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC+imm lands in ALUOut for branch/JAL targets
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.op)
          OP_LOAD:          state_d = S_MEMADR;
          OP_STORE:         begin bus.ImmSrc = IMM_S; state_d = S_MEMADR; end
          OP_RTYPE:         state_d = S_EXECR;
          OP_ITYPE:         state_d = S_EXECI;
          OP_LUI, OP_AUIPC: begin bus.ImmSrc = IMM_U; state_d = S_UIMM; end
          OP_JAL:           begin bus.ImmSrc = IMM_J; state_d = S_JAL; end
          OP_JALR:          state_d = S_JALR;
          OP_BRANCH: begin
            bus.ImmSrc = IMM_B;
            state_d    = br_legal ? S_BRANCH : ill_next;
          end
          default:          state_d = ill_next;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = (bus.op == OP_STORE) ? IMM_S : IMM_I;
        state_d     = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read   = 1'b1;
        bus.AdrSrc = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_write     = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write  = 1'b1;
        bus.AdrSrc = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA = SRCA_RS1;
        alu_op      = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_UIMM: begin
        bus.ImmSrc  = IMM_U;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUSrcA = (bus.op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA = SRCA_RS1;
        alu_op      = ALUOP_SUB;
        pc_write    = taken;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC takes the DECODE target from ALUOut while the ALU forms OldPC+4 for ALUWB
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_write    = 1'b1;
        state_d     = S_ALUWB;
      end
      S_JALR: begin
        bus.ALUSrcA   = SRCA_RS1;
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
        pc_write      = 1'b1;
        state_d       = S_JALRLINK;
      end
      S_JALRLINK: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        reg_write     = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP:  illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // DECODE->FETCH only happens for a skipped illegal instruction, which does not retire
  assign retire = (state_q != S_FETCH) && (state_q != S_DECODE) && (state_d == S_FETCH);

  aludec u_aludec (
    .op5        (bus.op[5]),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .ALUOp      (alu_op),
    .ALUControl (bus.ALUControl)
  );

  // Reset abandons any access in flight: no strobe or enable leaves the block
  assign bus.MemRead  = mem_read  & ~reset;
  assign bus.MemWrite = mem_write & ~reset;
  assign bus.IRWrite  = ir_write  & ~reset;
  assign bus.PCWrite  = pc_write  & ~reset;
  assign bus.RegWrite = reg_write & ~reset;
  assign bus.illegal  = illegal   & ~reset;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with a per-instruction reference model
module tb_multicycle_ctrl;
  import mc_pkg::*;

  typedef struct packed {
    logic       mr, mw, adr, irw, pcw, rw;
    logic [1:0] a, b, res;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
    logic [7:0] ret;
  } ctrl_t;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_LUI = 4, K_AUIPC = 5,
                 K_JAL = 6, K_JALR = 7, K_BR = 8, K_ILL_BR = 9, K_ILL_OP = 10;
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_UIMM = 8, P_ALUWB = 9,
                 P_BRANCH = 10, P_JAL = 11, P_JALR = 12, P_LINK = 13, P_TRAP = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] op_v;
  logic [2:0] f3_v;
  logic       f7_v, mem_ready_v;
  logic [3:0] flags_v;  // {Zero, Neg, Carry, Ovf}

  multicycle_ctrl_if #(.CNT_W(4)) bus_a ();
  multicycle_ctrl_if #(.CNT_W(6)) bus_b ();

  multicycle_ctrl #(.CNT_W(4), .MEM_HANDSHAKE(1), .TRAP_ON_ILLEGAL(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  multicycle_ctrl #(.CNT_W(6), .MEM_HANDSHAKE(0), .TRAP_ON_ILLEGAL(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  assign bus_a.op = op_v;        assign bus_b.op = op_v;
  assign bus_a.funct3 = f3_v;    assign bus_b.funct3 = f3_v;
  assign bus_a.funct7b5 = f7_v;  assign bus_b.funct7b5 = f7_v;
  assign bus_a.Zero = flags_v[3];  assign bus_b.Zero = flags_v[3];
  assign bus_a.Neg = flags_v[2];   assign bus_b.Neg = flags_v[2];
  assign bus_a.Carry = flags_v[1]; assign bus_b.Carry = flags_v[1];
  assign bus_a.Ovf = flags_v[0];   assign bus_b.Ovf = flags_v[0];
  assign bus_a.mem_ready = mem_ready_v; assign bus_b.mem_ready = mem_ready_v;

  ctrl_t obs_a, obs_b;
  assign obs_a = '{mr: bus_a.MemRead, mw: bus_a.MemWrite, adr: bus_a.AdrSrc, irw: bus_a.IRWrite,
                   pcw: bus_a.PCWrite, rw: bus_a.RegWrite, a: bus_a.ALUSrcA, b: bus_a.ALUSrcB,
                   res: bus_a.ResultSrc, imm: bus_a.ImmSrc, alu: bus_a.ALUControl,
                   ill: bus_a.illegal, ret: {4'b0, bus_a.retired}};
  assign obs_b = '{mr: bus_b.MemRead, mw: bus_b.MemWrite, adr: bus_b.AdrSrc, irw: bus_b.IRWrite,
                   pcw: bus_b.PCWrite, rw: bus_b.RegWrite, a: bus_b.ALUSrcA, b: bus_b.ALUSrcB,
                   res: bus_b.ResultSrc, imm: bus_b.ImmSrc, alu: bus_b.ALUControl,
                   ill: bus_b.illegal, ret: {2'b0, bus_b.retired}};

  int    active = 0;  // 0: dut_a (handshake, trap, 4-bit counter); 1: dut_b (no handshake, skip, 6-bit)
  int    kind;
  int    exp_ret;
  bit    taken_exp;
  logic [3:0] br_flags;
  int    n_cmp = 0;
  int    n_fail = 0;
  ctrl_t exp_q[$];
  string tag_q[$];
  string knames[11] = '{"lw", "sw", "rtype", "itype", "lui", "auipc", "jal", "jalr",
                        "branch", "ill_branch", "ill_op"};

  function automatic bit hs();   return active == 0; endfunction
  function automatic bit trap(); return active == 0; endfunction
  function automatic bit rb();   return 1'($urandom); endfunction
  function automatic bit done_rdy(); return hs() ? 1'b1 : rb(); endfunction

  // ISA meaning of the R/I arithmetic instruction in flight
  function automatic logic [3:0] alu_of(input bit is_imm);
    case (f3_v)
      3'd0:    return (!is_imm && f7_v) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7_v ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] fmt_of_kind();
    case (kind)
      K_STORE:          return 3'b001;
      K_BR, K_ILL_BR:   return 3'b010;
      K_LUI, K_AUIPC:   return 3'b011;
      K_JAL:            return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic ctrl_t expect_word(input int ph, input bit rdy_eff, input bit rst);
    ctrl_t w;
    int    cw;
    w     = '0;
    w.alu = ALU_ADD;
    cw    = (active == 0) ? 4 : 6;
    w.ret = 8'(exp_ret % (1 << cw));
    case (ph)
      P_FETCH:  begin w.mr = 1; w.b = 2'b10; w.res = 2'b10; w.irw = rdy_eff; w.pcw = rdy_eff; end
      P_DECODE: begin w.a = 2'b01; w.b = 2'b01; w.imm = fmt_of_kind(); end
      P_MEMADR: begin w.a = 2'b10; w.b = 2'b01; w.imm = (kind == K_STORE) ? 3'b001 : 3'b000; end
      P_MEMRD:  begin w.mr = 1; w.adr = 1; end
      P_MEMWB:  begin w.res = 2'b01; w.rw = 1; end
      P_MEMWR:  begin w.mw = 1; w.adr = 1; end
      P_EXECR:  begin w.a = 2'b10; w.alu = alu_of(1'b0); end
      P_EXECI:  begin w.a = 2'b10; w.b = 2'b01; w.alu = alu_of(1'b1); end
      P_UIMM:   begin w.imm = 3'b011; w.b = 2'b01; w.a = (kind == K_LUI) ? 2'b11 : 2'b01; end
      P_ALUWB:  w.rw = 1;
      P_BRANCH: begin w.a = 2'b10; w.alu = ALU_SUB; w.pcw = taken_exp; end
      P_JAL:    begin w.a = 2'b01; w.b = 2'b10; w.pcw = 1; end
      P_JALR:   begin w.a = 2'b10; w.b = 2'b01; w.res = 2'b10; w.pcw = 1; end
      P_LINK:   begin w.a = 2'b01; w.b = 2'b10; w.res = 2'b10; w.rw = 1; end
      default:  w.ill = 1;
    endcase
    if (rst) begin
      w.mr = 0; w.mw = 0; w.irw = 0; w.pcw = 0; w.rw = 0; w.ill = 0;
    end
    return w;
  endfunction

  // Drive one cycle, queue its expected controls, advance to just after the next edge
  task automatic step(input int ph, input bit mr, input bit rst, input string t);
    bit rdy_eff;
    rdy_eff     = hs() ? mr : 1'b1;
    reset       = rst;
    mem_ready_v = mr;
    flags_v     = (ph == P_BRANCH) ? br_flags : 4'($urandom);
    exp_q.push_back(expect_word(ph, rdy_eff, rst));
    tag_q.push_back($sformatf("%s.%s", knames[kind], t));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_ret = 0;
  endtask

  task automatic setup_fields(input int k);
    logic [31:0] ra, rb_v;
    logic [32:0] diff;
    logic [6:0]  ill_ops[5];
    int          br_f3[6];
    ill_ops = '{7'b0000000, 7'b0001111, 7'b1110011, 7'b1111111, 7'b0101111};
    br_f3   = '{0, 1, 4, 5, 6, 7};
    f3_v = 3'($urandom);
    f7_v = rb();
    case (k)
      K_LOAD:   op_v = 7'b0000011;
      K_STORE:  op_v = 7'b0100011;
      K_R:      op_v = 7'b0110011;
      K_I:      op_v = 7'b0010011;
      K_LUI:    op_v = 7'b0110111;
      K_AUIPC:  op_v = 7'b0010111;
      K_JAL:    op_v = 7'b1101111;
      K_JALR:   op_v = 7'b1100111;
      K_BR:     begin op_v = 7'b1100011; f3_v = 3'(br_f3[$urandom_range(0, 5)]); end
      K_ILL_BR: begin op_v = 7'b1100011; f3_v = 3'($urandom_range(2, 3)); end
      default:  op_v = ill_ops[$urandom_range(0, 4)];
    endcase
    // Operands for a branch; flags are what the ALU reports for rs1-rs2
    ra   = $urandom;
    rb_v = ($urandom_range(0, 3) == 0) ? ra : $urandom;
    diff = {1'b0, ra} + {1'b0, ~rb_v} + 33'd1;
    br_flags = {diff[31:0] == 32'd0, diff[31], diff[32],
                (ra[31] != rb_v[31]) && (diff[31] != ra[31])};
    case (f3_v)
      3'd0:    taken_exp = (ra == rb_v);
      3'd1:    taken_exp = (ra != rb_v);
      3'd4:    taken_exp = ($signed(ra) < $signed(rb_v));
      3'd5:    taken_exp = ($signed(ra) >= $signed(rb_v));
      3'd6:    taken_exp = (ra < rb_v);
      default: taken_exp = (ra >= rb_v);
    endcase
  endtask

  task automatic run_instr(input int k, input int fw, input int mw);
    int nfw, nmw;
    bit retires;
    kind    = k;
    retires = 1'b1;
    setup_fields(k);
    nfw = hs() ? ((fw < 0) ? int'($urandom_range(0, 2)) : fw) : 0;
    nmw = hs() ? ((mw < 0) ? int'($urandom_range(0, 2)) : mw) : 0;
    for (int i = 0; i < nfw; i++) step(P_FETCH, 1'b0, 1'b0, "fetch_wait");
    step(P_FETCH, done_rdy(), 1'b0, "fetch");
    step(P_DECODE, rb(), 1'b0, "decode");
    case (k)
      K_LOAD: begin
        step(P_MEMADR, rb(), 1'b0, "memadr");
        for (int i = 0; i < nmw; i++) step(P_MEMRD, 1'b0, 1'b0, "memread_wait");
        step(P_MEMRD, done_rdy(), 1'b0, "memread");
        step(P_MEMWB, rb(), 1'b0, "memwb");
      end
      K_STORE: begin
        step(P_MEMADR, rb(), 1'b0, "memadr");
        for (int i = 0; i < nmw; i++) step(P_MEMWR, 1'b0, 1'b0, "memwrite_wait");
        step(P_MEMWR, done_rdy(), 1'b0, "memwrite");
      end
      K_R:            begin step(P_EXECR, rb(), 1'b0, "execr"); step(P_ALUWB, rb(), 1'b0, "aluwb"); end
      K_I:            begin step(P_EXECI, rb(), 1'b0, "execi"); step(P_ALUWB, rb(), 1'b0, "aluwb"); end
      K_LUI, K_AUIPC: begin step(P_UIMM, rb(), 1'b0, "uimm"); step(P_ALUWB, rb(), 1'b0, "aluwb"); end
      K_JAL:          begin step(P_JAL, rb(), 1'b0, "jal"); step(P_ALUWB, rb(), 1'b0, "aluwb"); end
      K_JALR:         begin step(P_JALR, rb(), 1'b0, "jalr"); step(P_LINK, rb(), 1'b0, "jalrlink"); end
      K_BR:           step(P_BRANCH, rb(), 1'b0, "branch");
      default: begin
        retires = 1'b0;
        if (trap()) begin
          repeat (3) step(P_TRAP, rb(), 1'b0, "trap");
          step(P_TRAP, rb(), 1'b1, "trap_reset");
          exp_ret = 0;
        end
      end
    endcase
    if (retires) exp_ret++;
  endtask

  // Store whose write is still waiting when reset arrives
  task automatic store_reset();
    kind = K_STORE;
    setup_fields(K_STORE);
    step(P_FETCH, 1'b1, 1'b0, "fetch");
    step(P_DECODE, rb(), 1'b0, "decode");
    step(P_MEMADR, rb(), 1'b0, "memadr");
    step(P_MEMWR, 1'b0, 1'b0, "memwrite_wait");
    step(P_MEMWR, 1'b1, 1'b1, "memwrite_reset");
    exp_ret = 0;
  endtask

  always @(negedge clk) begin : monitor
    ctrl_t e, got;
    string t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = (active == 0) ? obs_a : obs_b;
      n_cmp++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s (dut %0d): got %h required %h", t, active, got, e);
      end
    end
  end

  initial begin
    reset = 1'b1; op_v = '0; f3_v = '0; f7_v = 1'b0; mem_ready_v = 1'b0; flags_v = '0;
    exp_ret = 0; kind = K_R; br_flags = '0; taken_exp = 1'b0;
    active = 0;
    do_reset();
    run_instr(K_R, 0, 0);
    run_instr(K_LOAD, 2, 3);
    run_instr(K_LUI, 0, 0);
    run_instr(K_AUIPC, 0, 0);
    run_instr(K_JALR, 1, 0);
    run_instr(K_STORE, 0, 2);
    repeat (120) run_instr(int'($urandom_range(K_LOAD, K_BR)), -1, -1);
    store_reset();
    repeat (40) run_instr(int'($urandom_range(K_LOAD, K_BR)), -1, -1);
    run_instr(K_ILL_BR, -1, -1);
    repeat (20) run_instr(int'($urandom_range(K_LOAD, K_BR)), -1, -1);
    run_instr(K_ILL_OP, -1, -1);
    run_instr(K_R, 0, 0);

    active = 1;
    do_reset();
    run_instr(K_ILL_BR, -1, -1);
    run_instr(K_ILL_OP, -1, -1);
    repeat (150) run_instr(int'($urandom_range(K_LOAD, K_ILL_OP)), -1, -1);
    run_instr(K_R, 0, 0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
